// File: rtl/dsp_mac_accum.sv
// Pre-adder / multiplier / accumulator with frame control.
// Each accepted sample contributes A * (D +/- B) to a frame sum that starts
// at bias C. After ACC_LEN samples the result is held on P until OUT_READY.
module dsp_mac_accum #(
  parameter int A_WIDTH  = 18,
  parameter int B_WIDTH  = 18,
  parameter int P_WIDTH  = 48,
  parameter int ACC_LEN  = 16,
  parameter int SATURATE = 1
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic signed [A_WIDTH-1:0]  A,
  input  logic signed [B_WIDTH-1:0]  B,
  input  logic signed [B_WIDTH-1:0]  D,
  input  logic                       SUB,
  input  logic signed [P_WIDTH-1:0]  C,
  input  logic                       CLR,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic signed [P_WIDTH-1:0]  P,
  output logic                       OVF
);

  localparam int PRE_W  = B_WIDTH + 1;
  localparam int PROD_W = A_WIDTH + B_WIDTH + 1;
  localparam int SUM_W  = P_WIDTH + 1;
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ACC_LEN - 1);
  localparam logic signed [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Signed overflow of the one-bit-wider sum: the two top bits disagree.
  function automatic logic sum_ovf(input logic signed [SUM_W-1:0] s);
    return s[SUM_W-1] != s[SUM_W-2];
  endfunction

  // Narrow the wide sum back to P_WIDTH, clamping or wrapping on overflow.
  function automatic logic signed [P_WIDTH-1:0] sat_wrap(input logic signed [SUM_W-1:0] s);
    if ((SATURATE != 0) && (s[SUM_W-1] != s[SUM_W-2]))
      return s[SUM_W-1] ? P_MIN : P_MAX;
    return s[P_WIDTH-1:0];
  endfunction

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       in_ready_q, in_ready_d;
  logic                       vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic                       vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
  logic signed [P_WIDTH-1:0]  acc_q, acc_d;
  logic                       ovf_q, ovf_d;
  logic                       out_valid_q, out_valid_d;

  logic signed [A_WIDTH-1:0]  a_p1_q;
  logic signed [PRE_W-1:0]    pre_p1_q;
  logic signed [PROD_W-1:0]   prod_p2_q;

  logic signed [PRE_W-1:0]    d_ext, b_ext, pre_d;
  logic signed [PROD_W-1:0]   a_ext, pre_ext, prod_d;
  logic signed [SUM_W-1:0]    sum_d;
  logic                       accept;

  // CLR wins over a simultaneous transfer, so nothing enters the pipe then.
  assign accept = IN_VALID && in_ready_q && !CLR;

  // Stage 0 -> 1: pre-adder on operands widened by one bit.
  assign d_ext = PRE_W'(D);
  assign b_ext = PRE_W'(B);
  assign pre_d = SUB ? (d_ext - b_ext) : (d_ext + b_ext);

  // Stage 1 -> 2: full-width signed product.
  assign a_ext   = PROD_W'(a_p1_q);
  assign pre_ext = PROD_W'(pre_p1_q);
  assign prod_d  = a_ext * pre_ext;

  // Stage 2 -> 3: accumulate with one guard bit for overflow detection.
  assign sum_d = SUM_W'(acc_q) + SUM_W'(prod_p2_q);

  // Datapath operand registers; qualified by the valids, so no reset needed.
  always_ff @(posedge CLK) begin
    if (accept) begin
      a_p1_q   <= A;
      pre_p1_q <= pre_d;
    end
    if (vld_p1_q) begin
      prod_p2_q <= prod_d;
    end
  end

  // Next-state logic for the frame FSM, pipeline valids and accumulator.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    vld_p1_d    = accept;
    last_p1_d   = accept && (cnt_q == LAST_IDX);
    vld_p2_d    = vld_p1_q;
    last_p2_d   = last_p1_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (CLR) begin
      state_d     = ACCUM;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      vld_p1_d    = 1'b0;
      last_p1_d   = 1'b0;
      vld_p2_d    = 1'b0;
      last_p2_d   = 1'b0;
      acc_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (vld_p2_q) begin
        acc_d = sat_wrap(sum_d);
        if (sum_ovf(sum_d)) ovf_d = 1'b1;
      end
      // The pipe is always empty when a frame starts, so loading C here
      // never collides with a product arriving at the accumulator.
      if (accept) begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == '0) acc_d = C;
      end
      unique case (state_q)
        ACCUM: begin
          in_ready_d = 1'b1;
          if (accept && (cnt_q == LAST_IDX)) begin
            in_ready_d = 1'b0;
            state_d    = DRAIN;
          end
        end
        DRAIN: begin
          in_ready_d = 1'b0;
          if (vld_p2_q && last_p2_q) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
          end
        end
        HOLD: begin
          in_ready_d = 1'b0;
          if (OUT_READY) begin
            state_d     = ACCUM;
            cnt_d       = '0;
            acc_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // Control and accumulator state; reset discards any partial frame.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      vld_p2_q    <= 1'b0;
      last_p2_q   <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      vld_p1_q    <= vld_p1_d;
      last_p1_q   <= last_p1_d;
      vld_p2_q    <= vld_p2_d;
      last_p2_q   <= last_p2_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OVF       = ovf_q;
  assign P         = out_valid_q ? acc_q : '0;

endmodule

// File: doc/dsp_mac_accum.md
DSP_MAC_ACCUM -- requirements
Module: dsp_mac_accum

Interface
REQ-001 The module SHALL have parameter A_WIDTH, default 18, signed multiplier A operand width.
REQ-002 The module SHALL have parameter B_WIDTH, default 18, signed B/D operand width.
REQ-003 The module SHALL have parameter P_WIDTH, default 48, signed accumulator/result width; P_WIDTH >= A_WIDTH+B_WIDTH+1.
REQ-004 The module SHALL have parameter ACC_LEN, default 16, products summed per frame; range 1..65535.
REQ-005 The module SHALL have parameter SATURATE, default 1; 1 = clamp accumulator, 0 = two's-complement wrap.
REQ-006 The module SHALL have port CLK, input, 1, the single clock; all logic rising-edge.
REQ-007 The module SHALL have port RSTN, input, 1, asynchronous active-low reset.
REQ-008 The module SHALL have port IN_VALID, input, 1, a sample is presented.
REQ-009 The module SHALL have port IN_READY, output, 1, the sample is accepted this cycle when IN_VALID is high.
REQ-010 The module SHALL have ports A (A_WIDTH), B (B_WIDTH) and D (B_WIDTH), inputs, signed operands.
REQ-011 The module SHALL have port SUB, input, 1, pre-adder select: 1 = D-B, 0 = D+B.
REQ-012 The module SHALL have port C, input, P_WIDTH, signed frame bias.
REQ-013 The module SHALL have port CLR, input, 1, synchronous frame abort.
REQ-014 The module SHALL have ports OUT_VALID (output, 1), OUT_READY (input, 1), P (output, P_WIDTH, signed result) and OVF (output, 1, sticky frame overflow).

Function
REQ-015 A transfer SHALL occur on a rising edge with IN_VALID=1 and IN_READY=1; the sample is accepted.
REQ-016 Stage 1 SHALL register A and the pre-add result D±B, sign-extended to B_WIDTH+1 bits, per SUB.
REQ-017 Stage 2 SHALL register the signed product of the stage-1 values (A_WIDTH+B_WIDTH+1 bits).
REQ-018 Stage 3 SHALL add the product, sign-extended to P_WIDTH, into the accumulator.
REQ-019 A product SHALL enter the accumulator exactly 3 cycles after its sample is accepted.
REQ-020 On acceptance of the first sample of a frame, C SHALL be loaded as the accumulator start value, so that the result is C + sum of ACC_LEN products.
REQ-021 The FSM SHALL have states ACCUM, DRAIN and HOLD.
REQ-022 In ACCUM, IN_READY SHALL be 1 while fewer than ACC_LEN samples have been accepted; on the ACC_LEN-th acceptance, IN_READY SHALL drop in the next cycle and the FSM SHALL enter DRAIN.
REQ-023 DRAIN SHALL wait until the final product is accumulated, then enter HOLD.
REQ-024 OUT_VALID SHALL rise exactly 3 cycles after the last acceptance.
REQ-025 HOLD SHALL keep OUT_VALID=1 with P and OVF stable until OUT_READY=1.
REQ-026 On the OUT_READY=1 edge in HOLD, the block SHALL clear the accumulator, sample counter and OVF, set OUT_VALID=0 and IN_READY=1 in the next cycle, and enter ACCUM.
REQ-027 In DRAIN and HOLD, IN_READY SHALL be 0.
REQ-028 With SATURATE=1, an accumulation exceeding the signed P_WIDTH range SHALL clamp to +max or -min and set OVF.
REQ-029 With SATURATE=0, the accumulation SHALL wrap, and OVF SHALL still be set on signed overflow.
REQ-030 OVF SHALL remain set until frame end or CLR.
REQ-031 CLR=1 SHALL, in any state, invalidate the pipeline, zero the accumulator, counter and OVF, deassert OUT_VALID and enter ACCUM.
REQ-032 CLR SHALL have priority over a simultaneous input transfer or OUT_READY; no sample is accepted in a CLR cycle.
REQ-033 P SHALL be 0 whenever OUT_VALID=0.
REQ-034 With ACC_LEN=1, the FSM SHALL go ACCUM->DRAIN after each acceptance.

Reset
REQ-035 RSTN=0 SHALL immediately force state ACCUM, the counter, accumulator, pipeline valids and OVF to 0, P=0, OUT_VALID=0 and IN_READY=0.
REQ-036 IN_READY SHALL become 1 on the first rising edge after RSTN deasserts.
REQ-037 Reset asserted mid-frame or in HOLD SHALL discard all partial results, with no output produced.

Verification
REQ-038 The bench SHALL cover: ACC_LEN=4, C=10, samples A=2, B=3, D=5, SUB=0 every cycle -> P=10+4*16=74, OUT_VALID 3 cycles after 4th accept, OVF=0.
REQ-039 The bench SHALL cover: SUB=1, A=-3, B=7, D=2, ACC_LEN=4, C=0 -> P=4*15=60; OUT_READY held low 5 cycles -> P stable and IN_READY=0 throughout.
REQ-040 The bench SHALL cover: P_WIDTH=36, SATURATE=1, C=2^35-1, product +1 -> P=2^35-1, OVF=1; SATURATE=0 -> P=-2^35, OVF=1.
REQ-041 The bench SHALL cover: CLR asserted after 2 of 4 samples, simultaneous with IN_VALID -> sample rejected, next frame result excludes the first 2 samples.
REQ-042 The bench SHALL cover: IN_VALID gaps (random bubbles) -> same P as gap-free run; back-to-back frames with OUT_READY tied high -> one result per frame, none lost.
REQ-043 The bench SHALL cover: RSTN pulsed low mid-DRAIN -> OUT_VALID never asserts, outputs 0 immediately, IN_READY=1 one edge after release.
